rc4_keystream_gen: RTL and testbench

RC4_KEYSTREAM_GEN -- requirements
Module: rc4_keystream_gen

---
 rtl/rc4_keystream_gen.sv | 131 +++++++++++++
 tb/tb_rc4_keystream_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_keystream_gen.sv
// RC4 keystream generator: one-cycle S-array fill, 256-cycle key schedule,
// then one keystream byte per request through a four-state PRGA sequence.
module rc4_keystream_gen (
  input  logic        clk,
  input  logic        n_rst_i,
  input  logic        gen_state_arr_i,
  input  logic [63:0] key_i,
  input  logic        gen_val_i,
  output logic        sarr_generated_o,
  output logic        val_ready_o,
  output logic [7:0]  keystream_o,
  output logic        busy_o
);

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE, FILL, KSA, READY, PRGA_I, PRGA_J, PRGA_SWAP, PRGA_OUT
  } state_t;

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  s_arr [256];
  logic [DATA_W-1:0]  s_nxt [256];
  logic [DATA_W-1:0]  idx_i, idx_j;
  logic [63:0]        key_q;
  logic               gsa_q;
  logic               rekey;
  logic [DATA_W-1:0]  key_byte, s_i, s_j, ksa_j, s_kj, prga_j, out_idx;

  assign rekey    = gen_state_arr_i & ~gsa_q;
  assign key_byte = key_q[{idx_i[2:0], 3'b000} +: 8];
  assign s_i      = s_arr[idx_i];
  assign s_j      = s_arr[idx_j];
  assign ksa_j    = idx_j + s_i + key_byte;
  assign s_kj     = s_arr[ksa_j];
  assign prga_j   = idx_j + s_i;
  assign out_idx  = s_i + s_j;
  assign busy_o   = (state == FILL) || (state == KSA) ||
                    (state inside {PRGA_I, PRGA_J, PRGA_SWAP, PRGA_OUT});

  always_ff @(posedge clk or negedge n_rst_i) begin
    if (!n_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // A re-key edge overrides whatever the FSM was doing, including PRGA requests.
  always_comb begin
    state_nxt = state;
    if (rekey) begin
      state_nxt = FILL;
    end else begin
      case (state)
        IDLE:      state_nxt = IDLE;
        FILL:      state_nxt = KSA;
        KSA:       if (idx_i == 8'hFF) state_nxt = READY;
        READY:     if (gen_val_i) state_nxt = PRGA_I;
        PRGA_I:    state_nxt = PRGA_J;
        PRGA_J:    state_nxt = PRGA_SWAP;
        PRGA_SWAP: state_nxt = PRGA_OUT;
        PRGA_OUT:  state_nxt = READY;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst_i) begin
    if (!n_rst_i) begin
      gsa_q            <= 1'b0;
      key_q            <= '0;
      idx_i            <= '0;
      idx_j            <= '0;
      sarr_generated_o <= 1'b0;
      val_ready_o      <= 1'b0;
      keystream_o      <= '0;
    end else begin
      gsa_q <= gen_state_arr_i;
      if (rekey) begin
        key_q            <= key_i;
        sarr_generated_o <= 1'b0;
        val_ready_o      <= 1'b0;
      end else begin
        case (state)
          FILL: begin
            idx_i <= '0;
            idx_j <= '0;
          end
          KSA: begin
            if (idx_i == 8'hFF) begin
              idx_i            <= '0;
              idx_j            <= '0;
              sarr_generated_o <= 1'b1;
            end else begin
              idx_i <= idx_i + 8'd1;
              idx_j <= ksa_j;
            end
          end
          READY:    if (gen_val_i) val_ready_o <= 1'b0;
          PRGA_I:   idx_i <= idx_i + 8'd1;
          PRGA_J:   idx_j <= prga_j;
          PRGA_OUT: begin
            keystream_o <= s_arr[out_idx];
            val_ready_o <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // S is pure data: no reset, only rewritten by FILL and the two swap points.
  always_comb begin
    s_nxt = s_arr;
    case (state)
      FILL: for (int n = 0; n < 256; n++) s_nxt[n] = 8'(n);
      KSA: begin
        s_nxt[idx_i] = s_kj;
        s_nxt[ksa_j] = s_i;
      end
      PRGA_SWAP: begin
        s_nxt[idx_i] = s_j;
        s_nxt[idx_j] = s_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    s_arr <= s_nxt;
  end

endmodule

// File: tb/tb_rc4_keystream_gen.sv
// Bench for rc4_keystream_gen: reference RC4 model feeding a byte scoreboard,
// table of keys plus directed re-key, reset and collision sequences.
module tb_rc4_keystream_gen;

  logic        clk = 1'b0;
  logic        n_rst_i;
  logic        gen_state_arr_i;
  logic [63:0] key_i;
  logic        gen_val_i;
  logic        sarr_generated_o;
  logic        val_ready_o;
  logic [7:0]  keystream_o;
  logic        busy_o;

  rc4_keystream_gen dut (
    .clk              (clk),
    .n_rst_i          (n_rst_i),
    .gen_state_arr_i  (gen_state_arr_i),
    .key_i            (key_i),
    .gen_val_i        (gen_val_i),
    .sarr_generated_o (sarr_generated_o),
    .val_ready_o      (val_ready_o),
    .keystream_o      (keystream_o),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q [$];
  logic [7:0] last_ks = 8'h00;
  logic       vr_prev = 1'b0;

  localparam logic [63:0] RFC_KEY = 64'h0807060504030201;

  // Reference RC4 state
  logic [7:0] ms [256];
  logic [7:0] mi, mj;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_ksa(input logic [63:0] k);
    logic [7:0] t;
    for (int n = 0; n < 256; n++) ms[n] = 8'(n);
    mj = 8'h00;
    for (int n = 0; n < 256; n++) begin
      mj = mj + ms[n] + k[8*(n%8) +: 8];
      t = ms[n]; ms[n] = ms[mj]; ms[mj] = t;
    end
    mi = 8'h00;
    mj = 8'h00;
  endtask

  task automatic model_next(output logic [7:0] b);
    logic [7:0] t;
    logic [7:0] idx;
    mi = mi + 8'd1;
    mj = mj + ms[mi];
    t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
    idx = ms[mi] + ms[mj];
    b = ms[idx];
  endtask

  // Compares every fresh byte against the head of the scoreboard.
  always @(negedge clk) begin
    if (val_ready_o && !vr_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {7'd0, val_ready_o}, 64'd0);
      end else begin
        check("keystream", keystream_o, exp_q.pop_front());
      end
    end
    vr_prev = val_ready_o;
  end

  task automatic rekey(input logic [63:0] k, input bit hold, input bit pulse_mid);
    key_i = k;
    gen_state_arr_i = 1'b1;
    tick();
    if (!hold) gen_state_arr_i = 1'b0;
    check("rekey_sarr_clr", sarr_generated_o, 0);
    check("rekey_vr_clr", val_ready_o, 0);
    check("rekey_busy", busy_o, 1);
    for (int k2 = 1; k2 <= 256; k2++) begin
      if (pulse_mid && k2 == 50) gen_val_i = 1'b1;
      if (k2 == 51) gen_val_i = 1'b0;
      tick();
    end
    check("sarr_e256", sarr_generated_o, 0);
    tick();
    check("sarr_e257", sarr_generated_o, 1);
    check("ready_busy", busy_o, 0);
    check("ks_hold_ksa", keystream_o, last_ks);
    check("vr_after_ksa", val_ready_o, 0);
    model_ksa(k);
  endtask

  task automatic request(input logic [7:0] exp, input int extra_at);
    exp_q.push_back(exp);
    gen_val_i = 1'b1;
    tick();
    gen_val_i = 1'b0;
    check("vr_drop", val_ready_o, 0);
    check("prga_busy", busy_o, 1);
    for (int k = 1; k <= 4; k++) begin
      if (extra_at == k) gen_val_i = 1'b1;
      tick();
      gen_val_i = 1'b0;
      if (k == 3) check("vr_early", val_ready_o, 0);
    end
    check("vr_rise", val_ready_o, 1);
    last_ks = exp;
    tick();
    check("vr_hold", val_ready_o, 1);
    check("ks_hold", keystream_o, last_ks);
  endtask

  typedef struct {
    logic [63:0] key;
    logic [7:0]  exp [8];
    bit          use_exp;
    int          extra_at;
    bit          pulse_mid;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mb;
    logic [7:0] e;
    bit         got;

    vecs[0].key = RFC_KEY;
    vecs[0].exp = '{8'h97, 8'hab, 8'h8a, 8'h1b, 8'hf0, 8'haf, 8'hb9, 8'h61};
    vecs[0].use_exp = 1'b1; vecs[0].extra_at = 2; vecs[0].pulse_mid = 1'b1;
    vecs[1].key = 64'h0;
    vecs[1].exp = '{default: 8'h00};
    vecs[1].use_exp = 1'b0; vecs[1].extra_at = 4; vecs[1].pulse_mid = 1'b0;
    vecs[2].key = 64'hFFFF_FFFF_FFFF_FFFF;
    vecs[2].exp = '{default: 8'h00};
    vecs[2].use_exp = 1'b0; vecs[2].extra_at = 3; vecs[2].pulse_mid = 1'b0;
    vecs[3].key = 64'h0123_4567_89AB_CDEF;
    vecs[3].exp = '{default: 8'h00};
    vecs[3].use_exp = 1'b0; vecs[3].extra_at = 0; vecs[3].pulse_mid = 1'b1;

    n_rst_i = 1'b0;
    gen_state_arr_i = 1'b0;
    gen_val_i = 1'b0;
    key_i = 64'h0;
    repeat (3) tick();
    check("rst_sarr", sarr_generated_o, 0);
    check("rst_vr", val_ready_o, 0);
    check("rst_ks", keystream_o, 0);
    check("rst_busy", busy_o, 0);
    n_rst_i = 1'b1;
    tick();

    // Request while IDLE must be dropped.
    gen_val_i = 1'b1;
    tick();
    gen_val_i = 1'b0;
    repeat (6) tick();
    check("idle_vr", val_ready_o, 0);
    check("idle_busy", busy_o, 0);
    check("idle_ks", keystream_o, 0);

    for (int v = 0; v < 4; v++) begin
      rekey(vecs[v].key, 1'b0, vecs[v].pulse_mid);
      for (int b = 0; b < 8; b++) begin
        model_next(mb);
        e = vecs[v].use_exp ? vecs[v].exp[b] : mb;
        request(e, (b == 2) ? vecs[v].extra_at : 0);
      end
    end

    // Held re-key request: exactly one schedule, then restart on a fresh edge.
    rekey(RFC_KEY, 1'b1, 1'b0);
    repeat (300 - 257) tick();
    check("hold_sarr", sarr_generated_o, 1);
    check("hold_busy", busy_o, 0);
    gen_state_arr_i = 1'b0;
    tick();
    request(8'h97, 0);
    request(8'hab, 0);
    request(8'h8a, 0);
    rekey(RFC_KEY, 1'b0, 1'b0);
    model_next(mb);
    request(8'h97, 0);

    // Re-key edge and byte request on the same READY cycle.
    gen_state_arr_i = 1'b1;
    gen_val_i = 1'b1;
    tick();
    gen_state_arr_i = 1'b0;
    gen_val_i = 1'b0;
    check("coll_vr", val_ready_o, 0);
    check("coll_sarr", sarr_generated_o, 0);
    check("coll_busy", busy_o, 1);
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      tick();
      if (sarr_generated_o) got = 1'b1;
    end
    check("coll_sarr_wait", got, 1);
    check("coll_ks_hold", keystream_o, last_ks);
    model_ksa(RFC_KEY);
    model_next(mb);
    request(8'h97, 0);

    // Asynchronous reset in the middle of a key schedule.
    key_i = vecs[3].key;
    gen_state_arr_i = 1'b1;
    tick();
    gen_state_arr_i = 1'b0;
    repeat (100) tick();
    check("midksa_busy", busy_o, 1);
    n_rst_i = 1'b0;
    #2;
    check("arst_sarr", sarr_generated_o, 0);
    check("arst_vr", val_ready_o, 0);
    check("arst_ks", keystream_o, 0);
    check("arst_busy", busy_o, 0);
    last_ks = 8'h00;

    // Re-key input already high when reset releases.
    key_i = RFC_KEY;
    gen_state_arr_i = 1'b1;
    tick();
    n_rst_i = 1'b1;
    tick();
    check("relhi_busy", busy_o, 1);
    repeat (256) tick();
    check("relhi_e256", sarr_generated_o, 0);
    tick();
    check("relhi_e257", sarr_generated_o, 1);
    gen_state_arr_i = 1'b0;
    model_ksa(RFC_KEY);
    model_next(mb);
    request(8'h97, 0);
    model_next(mb);
    request(8'hab, 0);

    repeat (4) tick();
    check("queue_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
